sprite_motion_sched: RTL and testbench

Frame-synchronous motion controller for up to NUM_SPRITES bouncing sprites overlaid on the 640x480 VGA raster. On each vblank-start pulse from the raster counters it sequences the sprite slots through one bounce-update datapath, one slot per cycle. It then atomically publishes all new positions to the pixel-compare logic. A ready/valid config port lets a host set each sprite's position, step and direction.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/sprite_axis_step.sv | 47 ++++
 rtl/sprite_motion_sched.sv | 152 +++++++++++++++
 tb/tb_sprite_motion_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and sprite/scheduler types.
package vga_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t     x;
    coord_t     y;
    logic [2:0] step;
    logic       incr_x;
    logic       incr_y;
  } sprite_state_t;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    PUBLISH
  } sched_state_t;

  // Power-on sprite: top-left corner, one pixel per update, heading down-right.
  localparam sprite_state_t SPRITE_RESET = '{
    x: '0, y: '0, step: 3'd1, incr_x: 1'b1, incr_y: 1'b1
  };

  function automatic coord_t clamp_coord(input coord_t v, input coord_t max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One axis of the bounce update: advance by step, stop and reverse at 0 / max.
module sprite_axis_step
  import vga_pkg::*;
(
  input  coord_t     p_i,
  input  logic [2:0] step_i,
  input  logic       incr_i,
  input  coord_t     max_i,
  output coord_t     p_next_o,
  output logic       incr_next_o
);

  // One spare bit so p+step near the top of the range cannot wrap.
  logic [COORD_W:0] p_ext;
  logic [COORD_W:0] step_ext;
  logic [COORD_W:0] sum;
  logic [COORD_W:0] diff;

  // Bounce arithmetic; a zero step leaves both position and direction alone.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    p_ext       = {1'b0, p_i};
    step_ext    = {{(COORD_W-2){1'b0}}, step_i};
    sum         = p_ext + step_ext;
    diff        = p_ext - step_ext;
    p_next_o    = p_i;
    incr_next_o = incr_i;
    if (step_i != 3'd0) begin
      if (incr_i) begin
        if (sum >= {1'b0, max_i}) begin
          p_next_o    = max_i;
          incr_next_o = 1'b0;
        end else begin
          p_next_o = sum[COORD_W-1:0];
        end
      end else begin
        if (p_ext <= step_ext) begin
          p_next_o    = '0;
          incr_next_o = 1'b1;
        end else begin
          p_next_o = diff[COORD_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/sprite_motion_sched.sv
// Frame-synchronous sprite motion scheduler: on frame_start, step every slot
// through one shared bounce datapath, then publish all positions at once.
// COORD_W must equal vga_pkg::COORD_W (the slot state uses coord_t).
module sprite_motion_sched #(
  parameter int NUM_SPRITES = 4,
  parameter int H_RES       = vga_pkg::H_RES,
  parameter int V_RES       = vga_pkg::V_RES,
  parameter int SPRITE_SIZE = 54,
  parameter int FRAME_DIV   = 1,
  parameter int COORD_W     = vga_pkg::COORD_W,
  localparam int ID_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic                           enable,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [ID_W-1:0]                cfg_id,
  input  logic [COORD_W-1:0]             cfg_x,
  input  logic [COORD_W-1:0]             cfg_y,
  input  logic [2:0]                     cfg_step,
  input  logic [1:0]                     cfg_dir,
  output logic [NUM_SPRITES*COORD_W-1:0] pos_x,
  output logic [NUM_SPRITES*COORD_W-1:0] pos_y,
  output logic                           pos_valid,
  output logic                           busy
);

  import vga_pkg::*;

  localparam coord_t     X_MAX    = coord_t'(H_RES - SPRITE_SIZE);
  localparam coord_t     Y_MAX    = coord_t'(V_RES - SPRITE_SIZE);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  sched_state_t  state_q, state_d;
  logic [7:0]    div_q, div_d;
  logic [ID_W-1:0] idx_q, idx_d;
  sprite_state_t work_q [NUM_SPRITES];
  sprite_state_t work_d [NUM_SPRITES];
  logic [NUM_SPRITES*COORD_W-1:0] pos_x_q, pos_y_q, pack_x, pack_y;
  logic          load_pos;
  logic          cfg_fire;

  sprite_state_t cur;
  coord_t        x_next, y_next;
  logic          incr_x_next, incr_y_next;

  assign cur       = work_q[idx_q];
  assign cfg_ready = (state_q == IDLE) && !frame_start;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign pos_valid = (state_q == PUBLISH);
  assign busy      = (state_q != IDLE);
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;

  sprite_axis_step u_step_x (
    .p_i         (cur.x),
    .step_i      (cur.step),
    .incr_i      (cur.incr_x),
    .max_i       (X_MAX),
    .p_next_o    (x_next),
    .incr_next_o (incr_x_next)
  );

  sprite_axis_step u_step_y (
    .p_i         (cur.y),
    .step_i      (cur.step),
    .incr_i      (cur.incr_y),
    .max_i       (Y_MAX),
    .p_next_o    (y_next),
    .incr_next_o (incr_y_next)
  );

  // Scheduler next state; load_pos fires on every edge that enters PUBLISH.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    load_pos = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          if (enable && (div_q == DIV_LAST)) begin
            div_d   = '0;
            idx_d   = '0;
            state_d = UPDATE;
          end else begin
            if (enable) div_d = div_q + 8'd1;
            state_d  = PUBLISH;
            load_pos = 1'b1;
          end
        end
      end
      UPDATE: begin
        idx_d = idx_q + ID_W'(1);
        if (idx_q == ID_W'(NUM_SPRITES - 1)) begin
          state_d  = PUBLISH;
          load_pos = 1'b1;
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working-slot writes: UPDATE and config are exclusive (config only in IDLE).
  always_comb begin
    work_d = work_q;
    if (state_q == UPDATE) begin
      work_d[idx_q] = '{x: x_next, y: y_next, step: cur.step,
                        incr_x: incr_x_next, incr_y: incr_y_next};
    end else if (cfg_fire && (int'(cfg_id) < NUM_SPRITES)) begin
      work_d[cfg_id] = '{x: clamp_coord(cfg_x, X_MAX), y: clamp_coord(cfg_y, Y_MAX),
                         step: cfg_step, incr_x: cfg_dir[0], incr_y: cfg_dir[1]};
    end
  end

  // Flatten the post-update slot state so publish sees this cycle's last write.
  always_comb begin
    pack_x = '0;
    pack_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      pack_x[i*COORD_W +: COORD_W] = work_d[i].x;
      pack_y[i*COORD_W +: COORD_W] = work_d[i].y;
    end
  end

  // State, divider, slot and published-position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      // NOTE: the slot array is flops, not RAM, and reset must define every slot, so it is cleared here.
      for (int i = 0; i < NUM_SPRITES; i++) work_q[i] <= SPRITE_RESET;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      if (load_pos) begin
        pos_x_q <= pack_x;
        pos_y_q <= pack_y;
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_sched.sv
// Directed bench for sprite_motion_sched: table of config/frame vectors plus
// hand sequences for handshake collision, FRAME_DIV and mid-update reset.
module tb_sprite_motion_sched;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start, enable, cfg_valid;
  logic [0:0]    cfg_id;
  logic [CW-1:0] cfg_x, cfg_y;
  logic [2:0]    cfg_step;
  logic [1:0]    cfg_dir;

  logic          cfg_ready_a, pv_a, busy_a;
  logic [2*CW-1:0] pos_x_a, pos_y_a;
  logic          cfg_ready_b, pv_b, busy_b;
  logic [2*CW-1:0] pos_x_b, pos_y_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sprite_motion_sched #(.NUM_SPRITES(2), .SPRITE_SIZE(54), .FRAME_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a), .cfg_id(cfg_id),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_step(cfg_step), .cfg_dir(cfg_dir),
    .pos_x(pos_x_a), .pos_y(pos_y_a), .pos_valid(pv_a), .busy(busy_a)
  );

  sprite_motion_sched #(.NUM_SPRITES(2), .SPRITE_SIZE(54), .FRAME_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b), .cfg_id(cfg_id),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_step(cfg_step), .cfg_dir(cfg_dir),
    .pos_x(pos_x_b), .pos_y(pos_y_b), .pos_valid(pv_b), .busy(busy_b)
  );

  typedef struct {
    logic          do_cfg;
    logic [0:0]    id;
    logic [CW-1:0] x, y;
    logic [2:0]    step;
    logic [1:0]    dir;
    logic          en;
    int            lat;
    logic [CW-1:0] x0, y0, x1, y1;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_pos(input string name, input bit on_b,
                           input logic [CW-1:0] x0, y0, x1, y1);
    check({name, " pos_x"}, on_b ? pos_x_b : pos_x_a, {x1, x0});
    check({name, " pos_y"}, on_b ? pos_y_b : pos_y_a, {y1, y0});
  endtask

  // Called at a negedge; returns at the negedge where the handshake has completed.
  task automatic cfg_write(input logic [0:0] id, input logic [CW-1:0] x, y,
                           input logic [2:0] step, input logic [1:0] dir);
    int n;
    cfg_valid = 1'b1; cfg_id = id; cfg_x = x; cfg_y = y; cfg_step = step; cfg_dir = dir;
    n = 0;
    while (!cfg_ready_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("cfg handshake timeout", n, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Pulse frame_start for one cycle; lat = negedges until pos_valid (20 = timeout).
  task automatic run_frame(input logic en, input bit on_b, output int lat);
    enable      = en;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    lat = 1;
    while (!(on_b ? pv_b : pv_a) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int exp_lat [6];
    logic [CW-1:0] exp_p [6];

    //                do  id  x     y    st   dir  en lat  x0   y0   x1   y1
    vecs[0] = '{1'b1, 1'b0, 100, 50,  3'd2, 2'b11, 1'b1, 3, 102, 52,  1,   1};
    vecs[1] = '{1'b1, 1'b1, 585, 2,   3'd2, 2'b01, 1'b1, 3, 104, 54,  586, 0};
    vecs[2] = '{1'b0, 1'b0, 0,   0,   3'd0, 2'b00, 1'b1, 3, 106, 56,  584, 2};
    vecs[3] = '{1'b0, 1'b0, 0,   0,   3'd0, 2'b00, 1'b0, 1, 106, 56,  584, 2};
    vecs[4] = '{1'b1, 1'b0, 700, 430, 3'd0, 2'b00, 1'b0, 1, 586, 426, 584, 2};
    vecs[5] = '{1'b0, 1'b0, 0,   0,   3'd0, 2'b00, 1'b1, 3, 586, 426, 582, 4};
    vecs[6] = '{1'b1, 1'b0, 3,   425, 3'd5, 2'b10, 1'b1, 3, 0,   426, 580, 6};
    vecs[7] = '{1'b1, 1'b1, 0,   0,   3'd7, 2'b00, 1'b1, 3, 5,   421, 0,   0};

    rst_n = 1'b0; frame_start = 1'b0; enable = 1'b1; cfg_valid = 1'b0;
    cfg_id = '0; cfg_x = '0; cfg_y = '0; cfg_step = '0; cfg_dir = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset / idle state
    check_pos("reset", 1'b0, 0, 0, 0, 0);
    check("reset pos_valid", pv_a, 0);
    check("reset busy", busy_a, 0);
    check("reset cfg_ready", cfg_ready_a, 1);

    // Table-driven config + frame vectors
    foreach (vecs[i]) begin
      if (vecs[i].do_cfg)
        cfg_write(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].step, vecs[i].dir);
      run_frame(vecs[i].en, 1'b0, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check_pos($sformatf("vec%0d", i), 1'b0, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
      @(negedge clk);
    end

    // frame_start and cfg_valid together: frame wins, config lands after publish
    enable = 1'b1; frame_start = 1'b1;
    cfg_valid = 1'b1; cfg_id = 1'b1; cfg_x = 10; cfg_y = 20; cfg_step = 3'd1; cfg_dir = 2'b11;
    #1;
    check("collide cfg_ready", cfg_ready_a, 0);
    @(negedge clk);
    frame_start = 1'b0;
    lat = 1;
    while (!pv_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("collide latency", lat, 3);
    check("collide cfg_ready at publish", cfg_ready_a, 0);
    check_pos("collide", 1'b0, 10, 416, 7, 7);
    @(negedge clk);
    check("cfg_ready after publish", cfg_ready_a, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    run_frame(1'b0, 1'b0, lat);
    check("deferred cfg latency", lat, 1);
    check_pos("deferred cfg", 1'b0, 10, 416, 10, 20);
    @(negedge clk);

    // Reset asserted while slot 1 is being updated
    enable = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    check("mid-update busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check_pos("abort", 1'b0, 0, 0, 0, 0);
    check("abort busy", busy_a, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort pos_valid", pv_a, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1'b1, 1'b0, lat);
    check("post-reset latency", lat, 3);
    check_pos("post-reset", 1'b0, 1, 1, 1, 1);
    @(negedge clk);

    // FRAME_DIV=3 instance: moves only every third frame, publishes every frame
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_write(1'b0, 100, 100, 3'd1, 2'b11);
    exp_lat = '{1, 1, 3, 1, 1, 3};
    exp_p   = '{100, 100, 101, 101, 101, 102};
    for (int f = 0; f < 6; f++) begin
      run_frame(1'b1, 1'b1, lat);
      check($sformatf("div frame%0d latency", f + 1), lat, exp_lat[f]);
      check($sformatf("div frame%0d x0", f + 1), pos_x_b[CW-1:0], exp_p[f]);
      check($sformatf("div frame%0d y0", f + 1), pos_y_b[CW-1:0], exp_p[f]);
      repeat (4) @(negedge clk);
    end
    run_frame(1'b0, 1'b1, lat);
    check("div frozen latency", lat, 1);
    check_pos("div frozen", 1'b1, 102, 102, 2, 2);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
